// File: rtl/fmult_accum_if.sv
// Handshake and operand bus between the control unit and the shared-FMULT
// predictor engine.
interface fmult_accum_if #(
  parameter int N_ZERO = 6,
  parameter int N_POLE = 2
);
  logic                   start;
  logic [16*N_ZERO-1:0]   b_bus;
  logic [11*N_ZERO-1:0]   dq_bus;
  logic [16*N_POLE-1:0]   a_bus;
  logic [11*N_POLE-1:0]   sr_bus;
  logic                   busy;
  logic                   done;
  logic [14:0]            se;
  logic [14:0]            sez;

  modport master (
    output start, b_bus, dq_bus, a_bus, sr_bus,
    input  busy, done, se, sez
  );

  modport slave (
    input  start, b_bus, dq_bus, a_bus, sr_bus,
    output busy, done, se, sez
  );
endinterface

// File: rtl/fmult_accum_seq.sv
// ADPCM adaptive-predictor sum of products: one FMULT time-shared over the
// zero-section (B*DQ) terms followed by the pole-section (A*SR) terms.
//
// state | meaning
// IDLE  | waiting for start; FMULT operands forced to zero
// RUN   | one term accumulated per clock, idx selects the term
module fmult_accum_seq #(
  parameter int N_ZERO = 6,
  parameter int N_POLE = 2,
  parameter int SAT_EN = 0
) (
  input  logic          clk,
  input  logic          reset,
  fmult_accum_if.slave  bus
);
  localparam int N     = N_ZERO + N_POLE;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ZLAST = IDX_W'(N_ZERO - 1);
  localparam logic [IDX_W:0]   IDX_LIMIT = (IDX_W+1)'(N);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic                 accept, last, recover;
  logic [IDX_W-1:0]     idx;
  logic [15:0]          accum, sei, sezi;
  logic                 busy, done;
  logic [16*N_ZERO-1:0] b_sh;
  logic [11*N_ZERO-1:0] dq_sh;
  logic [16*N_POLE-1:0] a_sh;
  logic [11*N_POLE-1:0] sr_sh;
  logic [15:0]          mul_a;
  logic [10:0]          mul_b;
  logic [15:0]          term;
  logic [16:0]          sum_wide;
  logic [15:0]          acc_nxt;

  // G.726 FMULT: 16-bit TC coefficient times 11-bit floating-point sample.
  function automatic logic [15:0] fmult(input logic [15:0] an, input logic [10:0] srn);
    logic        an_s, sr_s;
    logic [13:0] an_sh;
    logic [14:0] an_neg;
    logic [12:0] an_mag;
    logic [3:0]  an_exp, sr_exp;
    logic [18:0] mag_norm;
    logic [5:0]  an_mant, sr_mant;
    logic [11:0] prod, prod_rnd;
    logic [7:0]  wa_mant;
    logic [4:0]  wa_exp;
    logic [16:0] wa_base, wa_full;
    logic [14:0] wa_mag;
    an_s    = an[15];
    an_sh   = an[15:2];
    an_neg  = 15'h4000 - {1'b0, an_sh};
    an_mag  = an_s ? an_neg[12:0] : an_sh[12:0];
    an_exp  = 4'd0;
    for (int i = 0; i < 13; i++)
      if (an_mag[i]) an_exp = 4'(i + 1);
    mag_norm = {an_mag, 6'b0} >> an_exp;
    an_mant  = (an_mag == 13'd0) ? 6'd32 : mag_norm[5:0];
    sr_s     = srn[10];
    sr_exp   = srn[9:6];
    sr_mant  = srn[5:0];
    prod     = 12'(sr_mant) * 12'(an_mant);
    prod_rnd = prod + 12'd48;
    wa_mant  = prod_rnd[11:4];
    wa_exp   = {1'b0, sr_exp} + {1'b0, an_exp};
    wa_base  = {2'b0, wa_mant, 7'b0};
    if (wa_exp <= 5'd26) wa_full = wa_base >> (5'd26 - wa_exp);
    else                 wa_full = wa_base << (wa_exp - 5'd26);
    wa_mag = wa_full[14:0];
    return (sr_s ^ an_s) ? (16'd0 - {1'b0, wa_mag}) : {1'b0, wa_mag};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    recover   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if ({1'b0, idx} >= IDX_LIMIT) begin
          state_nxt = IDLE;
          recover   = 1'b1;
        end else if (idx == IDX_LAST) begin
          state_nxt = IDLE;
          last      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == RUN) begin
      for (int i = 0; i < N_ZERO; i++)
        if (idx == IDX_W'(i)) begin
          mul_a = b_sh[16*i +: 16];
          mul_b = dq_sh[11*i +: 11];
        end
      for (int i = 0; i < N_POLE; i++)
        if (idx == IDX_W'(N_ZERO + i)) begin
          mul_a = a_sh[16*i +: 16];
          mul_b = sr_sh[11*i +: 11];
        end
    end
  end

  // Saturation is re-applied after every term, so an intermediate clamp sticks.
  always_comb begin
    term     = fmult(mul_a, mul_b);
    sum_wide = {accum[15], accum} + {term[15], term};
    acc_nxt  = sum_wide[15:0];
    if (SAT_EN != 0) begin
      if (!sum_wide[16] && sum_wide[15])      acc_nxt = 16'h7FFF;
      else if (sum_wide[16] && !sum_wide[15]) acc_nxt = 16'h8000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      accum <= '0;
      sei   <= '0;
      sezi  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      b_sh  <= '0;
      dq_sh <= '0;
      a_sh  <= '0;
      sr_sh <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        b_sh  <= bus.b_bus;
        dq_sh <= bus.dq_bus;
        a_sh  <= bus.a_bus;
        sr_sh <= bus.sr_bus;
        accum <= '0;
        idx   <= '0;
        busy  <= 1'b1;
      end else if (state == RUN) begin
        if (recover) begin
          idx  <= '0;
          busy <= 1'b0;
        end else begin
          accum <= acc_nxt;
          idx   <= idx + 1'b1;
          if (idx == IDX_ZLAST) sezi <= acc_nxt;
          if (last) begin
            sei  <= acc_nxt;
            idx  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.se   = sei[15:1];
  assign bus.sez  = sezi[15:1];
endmodule

// File: tb/tb_fmult_accum_seq.sv
// Scoreboard bench: default engine plus a 4/4 pair (saturating and wrapping)
// driven with identical operands.
module tb_fmult_accum_seq;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fmult_accum_if #(.N_ZERO(6), .N_POLE(2)) if0 ();
  fmult_accum_if #(.N_ZERO(4), .N_POLE(4)) if1 ();
  fmult_accum_if #(.N_ZERO(4), .N_POLE(4)) if2 ();

  assign if2.start  = if1.start;
  assign if2.b_bus  = if1.b_bus;
  assign if2.dq_bus = if1.dq_bus;
  assign if2.a_bus  = if1.a_bus;
  assign if2.sr_bus = if1.sr_bus;

  fmult_accum_seq #(.N_ZERO(6), .N_POLE(2), .SAT_EN(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  fmult_accum_seq #(.N_ZERO(4), .N_POLE(4), .SAT_EN(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  fmult_accum_seq #(.N_ZERO(4), .N_POLE(4), .SAT_EN(0)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

  typedef struct {
    logic [14:0] sez;
    logic [14:0] se;
    int          cyc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: done with empty scoreboard (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (if0.done === 1'b1) begin
      if (q0.size() == 0) unexpected("u0");
      else begin
        automatic exp_t e = q0.pop_front();
        chk("u0 sez", if0.sez, e.sez);
        chk("u0 se", if0.se, e.se);
        chk("u0 done cycle", cyc, e.cyc);
        chk("u0 busy at done", if0.busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (if1.done === 1'b1) begin
      if (q1.size() == 0) unexpected("u1");
      else begin
        automatic exp_t e = q1.pop_front();
        chk("u1 sez", if1.sez, e.sez);
        chk("u1 se", if1.se, e.se);
        chk("u1 done cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (if2.done === 1'b1) begin
      if (q2.size() == 0) unexpected("u2");
      else begin
        automatic exp_t e = q2.pop_front();
        chk("u2 sez", if2.sez, e.sez);
        chk("u2 se", if2.se, e.se);
        chk("u2 done cycle", cyc, e.cyc);
      end
    end
  end

  // Accept edge is cyc+1; done is seen after accept edge + 8 for both configurations.
  task automatic run0(input logic [95:0] b, input logic [65:0] dq, input logic [31:0] a,
                      input logic [21:0] sr, input logic [14:0] esez, input logic [14:0] ese,
                      output int bcnt);
    int n;
    @(negedge clk);
    if0.b_bus = b; if0.dq_bus = dq; if0.a_bus = a; if0.sr_bus = sr;
    if0.start = 1'b1;
    q0.push_back('{esez, ese, cyc + 1 + 8});
    @(negedge clk);
    if0.start = 1'b0;
    bcnt = 0;
    n = 0;
    while (if0.done !== 1'b1 && n < 30) begin
      if (if0.busy === 1'b1) bcnt++;
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++; errors++;
      $display("FAIL u0 timeout: got no done expected done within 30 cycles");
    end
  endtask

  task automatic run1(input logic [63:0] b, input logic [43:0] dq, input logic [63:0] a,
                      input logic [43:0] sr, input logic [14:0] s1z, input logic [14:0] s1,
                      input logic [14:0] s2z, input logic [14:0] s2, input bit scramble);
    int n;
    @(negedge clk);
    if1.b_bus = b; if1.dq_bus = dq; if1.a_bus = a; if1.sr_bus = sr;
    if1.start = 1'b1;
    q1.push_back('{s1z, s1, cyc + 1 + 8});
    q2.push_back('{s2z, s2, cyc + 1 + 8});
    @(negedge clk);
    if1.start = 1'b0;
    if (scramble) begin
      if1.b_bus  = {$urandom(), $urandom()};
      if1.dq_bus = 44'({$urandom(), $urandom()});
      if1.a_bus  = {$urandom(), $urandom()};
      if1.sr_bus = 44'({$urandom(), $urandom()});
    end
    n = 0;
    while (if1.done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++; errors++;
      $display("FAIL pair timeout: got no done expected done within 30 cycles");
    end
  endtask

  initial begin
    int bc;
    int t;
    reset = 1'b1;
    if0.start = 1'b0; if0.b_bus = '0; if0.dq_bus = '0; if0.a_bus = '0; if0.sr_bus = '0;
    if1.start = 1'b0; if1.b_bus = '0; if1.dq_bus = '0; if1.a_bus = '0; if1.sr_bus = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", if0.busy, 0);
    chk("reset done", if0.done, 0);
    chk("reset se", if0.se, 0);
    chk("reset sez", if0.sez, 0);
    reset = 1'b0;

    // all-zero operands, plus busy window length
    run0('0, '0, '0, '0, 15'h0, 15'h0, bc);
    chk("busy cycles", bc, 8);

    // single zero term: 0.5 * DQ -> 1072
    run0({80'h0, 16'h4000}, {55'h0, 11'h2A0}, '0, '0, 15'h218, 15'h218, bc);
    // negative DQ sign
    run0({80'h0, 16'h4000}, {55'h0, 11'h6A0}, '0, '0, 15'h7DE8, 15'h7DE8, bc);
    // B0/B1 cancellation, two different DQ values
    run0({64'h0, 16'hE000, 16'h2000}, {44'h0, 11'h2A0, 11'h2A0}, '0, '0, 15'h0, 15'h0, bc);
    run0({64'h0, 16'hE000, 16'h2000}, {44'h0, 11'h5C7, 11'h5C7}, '0, '0, 15'h0, 15'h0, bc);
    // zero term + negative pole term: 1072 - 268
    run0({80'h0, 16'h4000}, {55'h0, 11'h2A0}, {16'h0, 16'hC000}, {11'h0, 11'h220},
         15'h218, 15'h192, bc);
    // last zero term and second pole term: sez=1340, se=2412
    run0({16'h4000, 64'h0, 16'h4000}, {11'h220, 44'h0, 11'h2A0}, {16'h4000, 16'h0},
         {11'h2A0, 11'h0}, 15'h29E, 15'h4B6, bc);

    // start held for 30 cycles: accepts every 9 cycles, four runs
    @(negedge clk);
    if0.b_bus = {80'h0, 16'h4000}; if0.dq_bus = {55'h0, 11'h2A0};
    if0.a_bus = '0; if0.sr_bus = '0;
    if0.start = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < 4; k++) q0.push_back('{15'h218, 15'h218, t + 8 + 9*k});
    repeat (30) @(negedge clk);
    if0.start = 1'b0;
    repeat (15) @(negedge clk);
    chk("back-to-back drained", q0.size(), 0);

    // asynchronous reset mid-run clears outputs at once; next run is fresh
    @(negedge clk);
    if0.b_bus = {80'h0, 16'h4000}; if0.dq_bus = {55'h0, 11'h6A0};
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrun reset se", if0.se, 0);
    chk("midrun reset sez", if0.sez, 0);
    chk("midrun reset busy", if0.busy, 0);
    chk("midrun reset done", if0.done, 0);
    @(negedge clk);
    reset = 1'b0;
    run0({80'h0, 16'h4000}, {55'h0, 11'h6A0}, '0, '0, 15'h7DE8, 15'h7DE8, bc);

    // 4/4 pair: max-magnitude terms, each +/-0x7600
    run1({4{16'h7FFF}}, {4{11'h3FF}}, {4{16'h7FFF}}, {4{11'h3FF}},
         15'h3FFF, 15'h3FFF, 15'h6C00, 15'h5800, 1'b0);
    run1({4{16'h7FFF}}, {4{11'h7FF}}, {4{16'h7FFF}}, {4{11'h7FF}},
         15'h4000, 15'h4000, 15'h1400, 15'h2800, 1'b0);
    run1({4{16'h7FFF}}, {4{11'h3FF}}, {4{16'h7FFF}}, {4{11'h3FF}},
         15'h3FFF, 15'h3FFF, 15'h6C00, 15'h5800, 1'b1);

    repeat (5) @(negedge clk);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    chk("q2 drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
